ram_arbiter: RTL and testbench

- Shares the single-ported ram model between two cache clients, e.g. an instruction-side and a data-side cache_f.
- Accepts one request per client through a valid/ready handshake and grants the ram round-robin.
- Sequences the ram's busy-level response and returns read data and completion to the granted client.
- Includes a watchdog that terminates a ram transaction which never completes.

---
 rtl/ram_arbiter_if.sv | 43 ++++
 rtl/ram_arbiter.sv | 124 ++++++++++++
 tb/tb_ram_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// Client and ram signal bundle for the two-client ram arbiter.
// slave is the arbiter side; master is the clients-plus-ram side.
interface ram_arbiter_if;
    logic        req0_valid;
    logic        req0_mode;
    logic [31:0] req0_address;
    logic [31:0] req0_data;
    logic        req0_ready;
    logic        req0_done;
    logic [31:0] req0_out;
    logic        req1_valid;
    logic        req1_mode;
    logic [31:0] req1_address;
    logic [31:0] req1_data;
    logic        req1_ready;
    logic        req1_done;
    logic [31:0] req1_out;
    logic        mem_req;
    logic        mem_mode;
    logic [31:0] mem_address;
    logic [31:0] mem_data;
    logic        mem_response;
    logic [31:0] mem_out;
    logic        err;

    modport slave (
        input  req0_valid, req0_mode, req0_address, req0_data,
        input  req1_valid, req1_mode, req1_address, req1_data,
        input  mem_response, mem_out,
        output req0_ready, req0_done, req0_out,
        output req1_ready, req1_done, req1_out,
        output mem_req, mem_mode, mem_address, mem_data, err
    );

    modport master (
        output req0_valid, req0_mode, req0_address, req0_data,
        output req1_valid, req1_mode, req1_address, req1_data,
        output mem_response, mem_out,
        input  req0_ready, req0_done, req0_out,
        input  req1_ready, req1_done, req1_out,
        input  mem_req, mem_mode, mem_address, mem_data, err
    );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-ported ram between two clients,
// with a watchdog that force-completes a ram transaction that hangs.
module ram_arbiter #(
    parameter int RAM_SIZE = 4096,
    parameter int TIMEOUT  = 64,
    parameter int CNT_W    = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    ram_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ISSUE, ACK, BUSY, DONE} state_t;

    localparam logic [31:0]      ADDR_MASK = 32'(RAM_SIZE - 1);
    localparam logic [CNT_W-1:0] WD_LAST   = CNT_W'(TIMEOUT - 1);

    state_t           state_q;
    logic             rr_q;
    logic             owner_q;
    logic             err_q;
    logic [CNT_W-1:0] wd_q;
    logic             rdy0_q, rdy1_q;
    logic             done0_q, done1_q;
    logic [31:0]      out0_q, out1_q;
    logic             mem_req_q;
    logic             mem_mode_q;
    logic [31:0]      mem_addr_q;
    logic [31:0]      mem_data_q;

    logic        gnt_vld_d;
    logic        gnt_d;
    logic        fin_ok_d;
    logic        fin_to_d;
    logic [31:0] fin_val_d;

    always_comb begin
        gnt_vld_d = bus.req0_valid | bus.req1_valid;
        gnt_d     = (bus.req0_valid & bus.req1_valid) ? rr_q : bus.req1_valid;
        fin_ok_d  = (state_q == BUSY) & ~bus.mem_response;
        // a genuine completion on the last watchdog cycle wins over the timeout
        fin_to_d  = (wd_q == WD_LAST) &
                    (((state_q == ACK) & ~bus.mem_response) |
                     ((state_q == BUSY) & bus.mem_response));
        fin_val_d = (fin_ok_d & ~mem_mode_q) ? bus.mem_out : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_q       <= 1'b0;
            owner_q    <= 1'b0;
            err_q      <= 1'b0;
            wd_q       <= '0;
            rdy0_q     <= 1'b0;
            rdy1_q     <= 1'b0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            out0_q     <= 32'h0;
            out1_q     <= 32'h0;
            mem_req_q  <= 1'b0;
            mem_mode_q <= 1'b0;
            mem_addr_q <= 32'h0;
            mem_data_q <= 32'h0;
        end else begin
            rdy0_q    <= 1'b0;
            rdy1_q    <= 1'b0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            mem_req_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (gnt_vld_d) begin
                        owner_q    <= gnt_d;
                        rdy0_q     <= ~gnt_d;
                        rdy1_q     <= gnt_d;
                        mem_req_q  <= 1'b1;
                        mem_mode_q <= gnt_d ? bus.req1_mode : bus.req0_mode;
                        mem_addr_q <= (gnt_d ? bus.req1_address
                                             : bus.req0_address) & ADDR_MASK;
                        mem_data_q <= gnt_d ? bus.req1_data : bus.req0_data;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    wd_q    <= '0;
                    state_q <= ACK;
                end
                ACK, BUSY: begin
                    wd_q <= wd_q + 1'b1;
                    if (fin_ok_d || fin_to_d) begin
                        state_q <= DONE;
                        err_q   <= err_q | fin_to_d;
                        if (owner_q) begin
                            out1_q  <= fin_val_d;
                            done1_q <= 1'b1;
                        end else begin
                            out0_q  <= fin_val_d;
                            done0_q <= 1'b1;
                        end
                    end else if (state_q == ACK && bus.mem_response) begin
                        state_q <= BUSY;
                    end
                end
                DONE: begin
                    rr_q    <= ~owner_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req0_ready  = rdy0_q;
    assign bus.req1_ready  = rdy1_q;
    assign bus.req0_done   = done0_q;
    assign bus.req1_done   = done1_q;
    assign bus.req0_out    = out0_q;
    assign bus.req1_out    = out1_q;
    assign bus.mem_req     = mem_req_q;
    assign bus.mem_mode    = mem_mode_q;
    assign bus.mem_address = mem_addr_q;
    assign bus.mem_data    = mem_data_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a ram model plus a cycle-level reference of the
// arbitration rules, checked every cycle, and directed literal checks.
module tb_ram_arbiter;
    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    logic rst_n;

    ram_arbiter_if bus();

    ram_arbiter #(
        .RAM_SIZE(4096),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (7)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // ram model state
    logic [31:0] mem [0:4095];
    int          lat = 3;
    bit          ram_dead = 1'b0;
    int          rphase = 0;
    int          rleft = 0;
    logic [11:0] raddr;
    logic        rmode;
    logic [31:0] rdata;
    int          fall_cyc = -1;

    // reference model state
    bit          m_active = 1'b0;
    bit          m_owner = 1'b0;
    bit          m_rr = 1'b0;
    int          rdy_cyc = -1;
    int          issue_cyc = -1;
    logic        e_mode = 1'b0;
    logic [31:0] e_addr = 32'h0;
    logic [31:0] e_data = 32'h0;
    logic [31:0] e_out0 = 32'h0;
    logic [31:0] e_out1 = 32'h0;
    bit          e_err = 1'b0;

    int glog[$];
    int n_rdy1 = 0;
    int n_memreq = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic sig(input int w);
        case (w)
            0:       return bus.req0_ready;
            1:       return bus.req1_ready;
            2:       return bus.req0_done;
            3:       return bus.req1_done;
            default: return bus.mem_req;
        endcase
    endfunction

    // waits up to budget negedges for a signal; n = negedges waited
    task automatic wait_ev(input int w, input int budget, input string name,
                           output int n);
        n = 0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (sig(w) === 1'b1) begin
                n = i;
                break;
            end
        end
        if (n == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: event not seen within %0d cycles, required 1", name, budget);
        end
    endtask

    // reference model, per-cycle compare and ram model
    initial begin
        bit          rst_edge;
        bit          dn;
        bit          to;
        int          k;
        logic [31:0] v;
        bus.mem_response = 1'b0;
        bus.mem_out      = 32'h0;
        rst_edge = 1'b1;
        k = 0;
        forever begin
            @(negedge clk);
            k++;
            dn = 1'b0;
            to = 1'b0;
            if (rst_edge) begin
                chk1("rst_ready0", bus.req0_ready, 1'b0);
                chk1("rst_ready1", bus.req1_ready, 1'b0);
                chk1("rst_done0", bus.req0_done, 1'b0);
                chk1("rst_done1", bus.req1_done, 1'b0);
                chk32("rst_out0", bus.req0_out, 32'h0);
                chk32("rst_out1", bus.req1_out, 32'h0);
                chk1("rst_mem_req", bus.mem_req, 1'b0);
                chk1("rst_mem_mode", bus.mem_mode, 1'b0);
                chk32("rst_mem_addr", bus.mem_address, 32'h0);
                chk32("rst_mem_data", bus.mem_data, 32'h0);
                chk1("rst_err", bus.err, 1'b0);
                m_active = 1'b0;
                m_owner  = 1'b0;
                m_rr     = 1'b0;
                rdy_cyc  = -1;
                e_mode   = 1'b0;
                e_addr   = 32'h0;
                e_data   = 32'h0;
                e_out0   = 32'h0;
                e_out1   = 32'h0;
                e_err    = 1'b0;
            end else begin
                dn = m_active && fall_cyc >= 0 && k == fall_cyc + 1;
                to = m_active && fall_cyc < 0 && k == issue_cyc + TIMEOUT + 1;
                if (dn || to) begin
                    v = (to || e_mode) ? 32'h0 : mem[e_addr[11:0]];
                    if (m_owner) e_out1 = v;
                    else e_out0 = v;
                    if (to) e_err = 1'b1;
                end
                chk1("ready0", bus.req0_ready, k == rdy_cyc && !m_owner);
                chk1("ready1", bus.req1_ready, k == rdy_cyc && m_owner);
                chk1("ready_excl", bus.req0_ready & bus.req1_ready, 1'b0);
                chk1("mem_req", bus.mem_req, k == rdy_cyc);
                chk1("done0", bus.req0_done, (dn || to) && !m_owner);
                chk1("done1", bus.req1_done, (dn || to) && m_owner);
                chk32("out0", bus.req0_out, e_out0);
                chk32("out1", bus.req1_out, e_out1);
                chk1("err", bus.err, e_err);
                chk1("mem_mode", bus.mem_mode, e_mode);
                chk32("mem_addr", bus.mem_address, e_addr);
                chk32("mem_data", bus.mem_data, e_data);
                if (bus.req0_ready === 1'b1) glog.push_back(0);
                if (bus.req1_ready === 1'b1) begin
                    glog.push_back(1);
                    n_rdy1++;
                end
                if (bus.mem_req === 1'b1) n_memreq++;
                if (dn || to) begin
                    m_active = 1'b0;
                    m_rr     = !m_owner;
                end
            end
            if (rst_n && !m_active && !(dn || to) &&
                (bus.req0_valid || bus.req1_valid)) begin
                m_owner   = (bus.req0_valid && bus.req1_valid) ? m_rr : bus.req1_valid;
                e_mode    = m_owner ? bus.req1_mode : bus.req0_mode;
                e_addr    = (m_owner ? bus.req1_address : bus.req0_address) & 32'h0000_0FFF;
                e_data    = m_owner ? bus.req1_data : bus.req0_data;
                m_active  = 1'b1;
                rdy_cyc   = k + 1;
                issue_cyc = k + 1;
                fall_cyc  = -1;
            end
            rst_edge = !rst_n;
            if (!rst_n) begin
                rphase = 0;
                bus.mem_response = 1'b0;
            end else if (bus.mem_req === 1'b1) begin
                if (!ram_dead) begin
                    rphase = 1;
                    raddr  = bus.mem_address[11:0];
                    rmode  = bus.mem_mode;
                    rdata  = bus.mem_data;
                end
            end else if (rphase == 1) begin
                bus.mem_response = 1'b1;
                rleft  = lat;
                rphase = 2;
            end else if (rphase == 2) begin
                rleft--;
                if (rleft == 0) begin
                    bus.mem_response = 1'b0;
                    if (rmode) begin
                        mem[raddr]  = rdata;
                        bus.mem_out = 32'hBAD0_BAD0;
                    end else begin
                        bus.mem_out = mem[raddr];
                    end
                    fall_cyc = k;
                    rphase   = 0;
                end
            end
        end
    end

    task automatic drive0(input logic vld, input logic md, input logic [31:0] a,
                          input logic [31:0] d);
        bus.req0_valid   = vld;
        bus.req0_mode    = md;
        bus.req0_address = a;
        bus.req0_data    = d;
    endtask

    task automatic drive1(input logic vld, input logic md, input logic [31:0] a,
                          input logic [31:0] d);
        bus.req1_valid   = vld;
        bus.req1_mode    = md;
        bus.req1_address = a;
        bus.req1_data    = d;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        next_cyc();
        rst_n = 1'b0;
        drive0(1'b0, 1'b0, 32'h0, 32'h0);
        drive1(1'b0, 1'b0, 32'h0, 32'h0);
        next_cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        int base;
        int cnt;
        int exp_g[4];
        rst_n = 1'b0;
        drive0(1'b0, 1'b0, 32'h0, 32'h0);
        drive1(1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 4096; i++) mem[i] = 32'hA500_0000 | 32'(i);
        mem[12'h010] = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // single read, busy for 3 cycles
        base = n_memreq;
        drive0(1'b1, 1'b0, 32'h10, 32'h0);
        wait_ev(0, 10, "t1_ready", n);
        chk32("t1_ready_latency", 32'(n), 32'd2);
        next_cyc();
        drive0(1'b0, 1'b0, 32'h0, 32'h0);
        wait_ev(2, 20, "t1_done", n);
        chk32("t1_out", bus.req0_out, 32'hDEAD_BEEF);
        chk1("t1_err", bus.err, 1'b0);
        chk32("t1_mem_req_count", 32'(n_memreq - base), 32'd1);

        // both clients valid every cycle from reset
        do_reset();
        glog.delete();
        drive0(1'b1, 1'b0, 32'h10, 32'h0);
        drive1(1'b1, 1'b0, 32'h1005, 32'h0);
        cnt = 0;
        for (int i = 0; i < 80 && cnt < 4; i++) begin
            @(negedge clk);
            if (bus.req0_done === 1'b1 || bus.req1_done === 1'b1) cnt++;
        end
        chk32("t2_done_count", 32'(cnt), 32'd4);
        next_cyc();
        drive0(1'b0, 1'b0, 32'h0, 32'h0);
        drive1(1'b0, 1'b0, 32'h0, 32'h0);
        exp_g = '{0, 1, 0, 1};
        chk32("t2_grant_count", 32'(glog.size()), 32'd4);
        for (int i = 0; i < 4 && i < glog.size(); i++)
            chk32("t2_grant_order", 32'(glog[i]), 32'(exp_g[i]));
        chk32("t2_wrap_out1", bus.req1_out, 32'hA500_0005);

        // write from client 1 with address wrap
        drive1(1'b1, 1'b1, 32'h1FFF, 32'h1234_5678);
        wait_ev(1, 10, "t3_ready", n);
        next_cyc();
        drive1(1'b0, 1'b0, 32'h0, 32'h0);
        wait_ev(3, 20, "t3_done", n);
        chk1("t3_mem_mode", bus.mem_mode, 1'b1);
        chk32("t3_mem_addr", bus.mem_address, 32'h0000_0FFF);
        chk32("t3_mem_data", bus.mem_data, 32'h1234_5678);
        chk32("t3_out1", bus.req1_out, 32'h0);
        chk32("t3_ram_written", mem[12'hFFF], 32'h1234_5678);

        // ram never responds: watchdog completes with error
        ram_dead = 1'b1;
        drive0(1'b1, 1'b0, 32'h20, 32'h0);
        wait_ev(0, 10, "t4_ready", n);
        next_cyc();
        drive0(1'b0, 1'b0, 32'h0, 32'h0);
        wait_ev(2, 100, "t4_done", n);
        chk32("t4_timeout_latency", 32'(n), 32'd65);
        chk32("t4_out0", bus.req0_out, 32'h0);
        chk1("t4_err", bus.err, 1'b1);
        next_cyc();
        ram_dead = 1'b0;
        drive1(1'b1, 1'b0, 32'h10, 32'h0);
        wait_ev(1, 10, "t4b_ready", n);
        next_cyc();
        drive1(1'b0, 1'b0, 32'h0, 32'h0);
        wait_ev(3, 20, "t4b_done", n);
        chk32("t4b_out1", bus.req1_out, 32'hDEAD_BEEF);
        chk1("t4b_err_sticky", bus.err, 1'b1);

        // reset while the ram is busy
        lat = 6;
        drive0(1'b1, 1'b0, 32'h10, 32'h0);
        wait_ev(4, 10, "t5_mem_req", n);
        next_cyc();
        drive0(1'b0, 1'b0, 32'h0, 32'h0);
        next_cyc();
        rst_n = 1'b0;
        next_cyc();
        rst_n = 1'b1;
        @(negedge clk);
        chk1("t5_err_cleared", bus.err, 1'b0);
        chk32("t5_out0_cleared", bus.req0_out, 32'h0);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.req0_done === 1'b1) cnt++;
        end
        chk32("t5_no_done", 32'(cnt), 32'd0);
        lat = 3;

        // client 1 withdraws while client 0 is granted
        base = n_rdy1;
        next_cyc();
        drive0(1'b1, 1'b0, 32'h10, 32'h0);
        drive1(1'b1, 1'b0, 32'h30, 32'h0);
        next_cyc();
        drive1(1'b0, 1'b0, 32'h0, 32'h0);
        wait_ev(0, 10, "t6_ready", n);
        next_cyc();
        drive0(1'b0, 1'b0, 32'h0, 32'h0);
        wait_ev(2, 20, "t6_done", n);
        chk32("t6_out0", bus.req0_out, 32'hDEAD_BEEF);
        repeat (10) @(negedge clk);
        chk32("t6_req1_ready_count", 32'(n_rdy1 - base), 32'd0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation still running, required finish");
        $fatal(1, "global timeout");
    end
endmodule
